// File: rtl/tinyrv_pkg.sv
// Shared definitions for the tinyrv byte-serial datapath.
//   REG_ADDR_W  : register index width (16 registers, x0 reads zero)
//   PHASE_W     : byte-lane select width
//   NUM_PHASES  : number of byte lanes per 32-bit word
//   LAST_PHASE  : index of the most significant byte lane
//   seq_state_t : operation sequencer state
package tinyrv_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int PHASE_W    = 2;
    localparam int NUM_PHASES = 2 ** PHASE_W;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/regfile_sequencer.sv
// Byte-serial operation sequencer for a 16 x 32-bit register file that is
// accessed one byte lane per cycle. One register-to-register operation is
// accepted per valid/ready handshake. The sequencer then walks byte lanes
// 0..3 (LSB first), chains the byte ALU carry, accumulates the zero flag and
// issues a one-cycle done pulse carrying the final flags.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         operation handshake from issue
//   req_rs1, req_rs2, req_rd      register indices of the operation
//   req_we, req_cin               write enable, carry into byte 0
//   flush                         squash the in-flight operation
//   rf_phase, rf_rs1, rf_rs2      byte lane and read indices to the regfile
//   rf_rd                         write index (0 = no architectural write)
//   alu_first, alu_last, alu_cin  byte ALU controls
//   alu_cout, alu_zero            byte ALU carry out / result byte zero
//   done_valid, done_carry,       completion pulse with final carry and
//   done_zero                     whole-word zero flag
module regfile_sequencer
    import tinyrv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [REG_ADDR_W-1:0] req_rs1,
    input  logic [REG_ADDR_W-1:0] req_rs2,
    input  logic [REG_ADDR_W-1:0] req_rd,
    input  logic                  req_we,
    input  logic                  req_cin,
    input  logic                  flush,
    output logic [PHASE_W-1:0]    rf_phase,
    output logic [REG_ADDR_W-1:0] rf_rs1,
    output logic [REG_ADDR_W-1:0] rf_rs2,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic                  alu_first,
    output logic                  alu_last,
    output logic                  alu_cin,
    input  logic                  alu_cout,
    input  logic                  alu_zero,
    output logic                  done_valid,
    output logic                  done_carry,
    output logic                  done_zero
);

    seq_state_t            r_state;
    logic [PHASE_W-1:0]    r_ph;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_we;
    logic                  r_carry;
    logic                  r_zero;
    logic                  r_done_valid;
    logic                  r_done_carry;
    logic                  r_done_zero;

    logic                  w_run;
    logic                  w_last;
    logic                  w_ready;
    logic                  w_accept;

    assign w_run    = (r_state == RUN);
    assign w_last   = w_run && (r_ph == LAST_PHASE);
    // Accepting during the last byte lets the next operation start with no
    // bubble; a flush cycle never accepts so the squash is clean.
    assign w_ready  = !flush && (!w_run || w_last);
    assign w_accept = req_valid && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ph         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_we         <= 1'b0;
            r_carry      <= 1'b0;
            r_zero       <= 1'b1;
            r_done_valid <= 1'b0;
            r_done_carry <= 1'b0;
            r_done_zero  <= 1'b0;
        end else begin
            // Done flags are only meaningful alongside the pulse; keep them
            // low otherwise so downstream sees clean zeros.
            r_done_valid <= 1'b0;
            r_done_carry <= 1'b0;
            r_done_zero  <= 1'b0;
            if (w_run && flush) begin
                // Squash: flags are left untouched and no done is reported.
                r_state <= IDLE;
                r_ph    <= '0;
            end else begin
                if (w_run) begin
                    r_carry <= alu_cout;
                    r_zero  <= r_zero & alu_zero;
                    r_ph    <= r_ph + PHASE_W'(1);
                    if (w_last) begin
                        r_done_valid <= 1'b1;
                        r_done_carry <= alu_cout;
                        r_done_zero  <= r_zero & alu_zero;
                        r_state      <= IDLE;
                    end
                end
                if (w_accept) begin
                    r_rs1   <= req_rs1;
                    r_rs2   <= req_rs2;
                    r_rd    <= req_rd;
                    r_we    <= req_we;
                    r_carry <= req_cin;
                    r_zero  <= 1'b1;
                    r_ph    <= '0;
                    r_state <= RUN;
                end
            end
        end
    end

    assign req_ready  = w_ready;
    assign rf_phase   = w_run ? r_ph : '0;
    assign rf_rs1     = w_run ? r_rs1 : '0;
    assign rf_rs2     = w_run ? r_rs2 : '0;
    // The register file writes every cycle; rd = 0 turns the write into a
    // harmless store to x0. flush must kill the write in the same cycle.
    assign rf_rd      = (w_run && r_we && !flush) ? r_rd : '0;
    assign alu_first  = w_run && (r_ph == '0);
    assign alu_last   = w_last;
    assign alu_cin    = w_run && r_carry;
    assign done_valid = r_done_valid;
    assign done_carry = r_done_carry;
    assign done_zero  = r_done_zero;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: a cycle-level driver plays a list
// of operations (directed then random) and records what each cycle and each
// completion must look like; a negedge monitor pops and compares.
module tb_regfile_sequencer;
    import tinyrv_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [REG_ADDR_W-1:0] req_rs1, req_rs2, req_rd;
    logic                  req_we, req_cin, flush;
    logic [PHASE_W-1:0]    rf_phase;
    logic [REG_ADDR_W-1:0] rf_rs1, rf_rs2, rf_rd;
    logic                  alu_first, alu_last, alu_cin;
    logic                  alu_cout, alu_zero;
    logic                  done_valid, done_carry, done_zero;

    regfile_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_we(req_we), .req_cin(req_cin), .flush(flush),
        .rf_phase(rf_phase), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
        .alu_first(alu_first), .alu_last(alu_last), .alu_cin(alu_cin),
        .alu_cout(alu_cout), .alu_zero(alu_zero),
        .done_valid(done_valid), .done_carry(done_carry), .done_zero(done_zero)
    );

    always #5 clk = ~clk;

    // kill: 0 none, 1 flush, 2 reset; applied in byte kph
    typedef struct {
        int       rs1, rs2, rd;
        bit       we, cin;
        bit [3:0] cout, zero;
        int       gap;
        int       kill, kph;
    } op_t;

    typedef struct {
        int phase, rs1, rs2, rd;
        bit first, last, cin, ready, dv;
    } cyc_t;

    typedef struct {
        int cyc;
        bit carry, zero;
    } done_t;

    op_t   reqs[$];
    cyc_t  tq[$];
    done_t dq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic op_t mk(input int rs1, rs2, rd, input bit we, cin,
                               input bit [3:0] cout, zero, input int gap, kill, kph);
        op_t o;
        o.rs1 = rs1; o.rs2 = rs2; o.rd = rd; o.we = we; o.cin = cin;
        o.cout = cout; o.zero = zero; o.gap = gap; o.kill = kill; o.kph = kph;
        return o;
    endfunction

    // Monitor: per-cycle trace plus completion scoreboard.
    initial begin
        cyc_t  r;
        done_t d;
        forever begin
            @(negedge clk);
            if (tq.size() > 0) begin
                r = tq.pop_front();
                chk("rf_phase",  int'(rf_phase),  r.phase);
                chk("rf_rs1",    int'(rf_rs1),    r.rs1);
                chk("rf_rs2",    int'(rf_rs2),    r.rs2);
                chk("rf_rd",     int'(rf_rd),     r.rd);
                chk("alu_first", int'(alu_first), int'(r.first));
                chk("alu_last",  int'(alu_last),  int'(r.last));
                chk("alu_cin",   int'(alu_cin),   int'(r.cin));
                chk("req_ready", int'(req_ready), int'(r.ready));
                chk("done_valid", int'(done_valid), int'(r.dv));
                if (!r.dv) begin
                    chk("done_carry_idle", int'(done_carry), 0);
                    chk("done_zero_idle",  int'(done_zero),  0);
                end
                if (done_valid) begin
                    if (dq.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        d = dq.pop_front();
                        chk("done_cycle", cyc, d.cyc);
                        chk("done_carry", int'(done_carry), int'(d.carry));
                        chk("done_zero",  int'(done_zero),  int'(d.zero));
                    end
                end
            end
        end
    end

    // Driver and reference model: an operation occupies four cycles, one
    // per byte; carry into byte k is the ALU carry out of byte k-1.
    initial begin
        op_t  cur;
        cyc_t r;
        done_t d;
        bit   inflight = 0;
        int   p = 0;
        int   gap_cnt;
        int   tail = 0;
        bit   dv_next = 0;
        bit   fl, rs, exp_ready, acc;

        rst = 1'b1; req_valid = 0; req_rs1 = 0; req_rs2 = 0; req_rd = 0;
        req_we = 0; req_cin = 0; flush = 0; alu_cout = 0; alu_zero = 0;

        reqs.push_back(mk(3, 4, 5, 1, 0, 4'b1001, 4'b1011, 5, 0, 0));
        reqs.push_back(mk(1, 2, 6, 1, 1, 4'b0110, 4'b1111, 3, 0, 0));
        reqs.push_back(mk(7, 8, 10, 1, 0, 4'b1010, 4'b0000, 0, 0, 0));
        reqs.push_back(mk(2, 3, 7, 0, 1, 4'b0101, 4'b1111, 2, 0, 0));
        reqs.push_back(mk(4, 5, 9, 1, 0, 4'b1111, 4'b1111, 2, 1, 1));
        reqs.push_back(mk(6, 1, 12, 1, 1, 4'b0011, 4'b0111, 1, 2, 2));
        reqs.push_back(mk(11, 12, 0, 1, 0, 4'b1000, 4'b1111, 3, 0, 0));
        for (int i = 0; i < 40; i++) begin
            int k = $urandom_range(0, 15);
            reqs.push_back(mk($urandom_range(0, 15), $urandom_range(0, 15),
                              $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                              4'($urandom_range(0, 15)),
                              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                              (k < 2) ? 1 : 0, $urandom_range(0, 3)));
        end
        gap_cnt = reqs[0].gap;

        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        while (tail < 3 && cyc < 20000) begin
            fl = 0; rs = 0;
            if (inflight) begin
                alu_cout = cur.cout[p];
                alu_zero = cur.zero[p];
                fl = (cur.kill == 1 && cur.kph == p);
                rs = (cur.kill == 2 && cur.kph == p);
            end else begin
                alu_cout = 1'($urandom_range(0, 1));
                alu_zero = 1'($urandom_range(0, 1));
                fl = ($urandom_range(0, 9) == 0);
            end
            flush = fl;
            rst   = rs;
            req_valid = (reqs.size() > 0) && (gap_cnt == 0);
            if (reqs.size() > 0) begin
                req_rs1 = 4'(reqs[0].rs1); req_rs2 = 4'(reqs[0].rs2);
                req_rd = 4'(reqs[0].rd); req_we = reqs[0].we; req_cin = reqs[0].cin;
            end
            exp_ready = !fl && (!inflight || p == 3);
            acc = req_valid && exp_ready && !rs;

            r.ready = exp_ready;
            r.dv    = dv_next;
            dv_next = 0;
            if (inflight) begin
                r.phase = p; r.rs1 = cur.rs1; r.rs2 = cur.rs2;
                r.rd    = (cur.we && !fl) ? cur.rd : 0;
                r.first = (p == 0); r.last = (p == 3);
                r.cin   = (p == 0) ? cur.cin : cur.cout[p-1];
                if (p == 3 && !fl && !rs) begin
                    d.cyc = cyc + 1; d.carry = cur.cout[3]; d.zero = (cur.zero == 4'hF);
                    dq.push_back(d);
                    dv_next = 1;
                end
            end else begin
                r.phase = 0; r.rs1 = 0; r.rs2 = 0; r.rd = 0;
                r.first = 0; r.last = 0; r.cin = 0;
            end
            tq.push_back(r);

            @(posedge clk); #1;

            if (rs) inflight = 0;
            else if (inflight) begin
                if (fl || p == 3) inflight = 0;
                else p++;
            end
            if (acc) begin
                cur = reqs.pop_front();
                inflight = 1; p = 0;
                if (reqs.size() > 0) gap_cnt = reqs[0].gap;
            end else if (gap_cnt > 0) begin
                gap_cnt--;
            end
            if (reqs.size() == 0 && !inflight) tail++;
            cyc++;
        end
        flush = 0; req_valid = 0; rst = 0;
        @(negedge clk); #1;
        chk("cycle_budget", (cyc < 20000) ? 1 : 0, 1);
        chk("done_leftover", dq.size(), 0);
        chk("trace_leftover", tq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Byte-serial operation sequencer for the 16 x 32-bit register file, which is accessed as 4 byte lanes selected by a 2-bit phase.
- Accepts one register-to-register operation per valid/ready handshake and drives phase, rs1, rs2 and rd for 4 consecutive cycles, LSB byte first.
- Carries the inter-byte carry and zero flag for the byte ALU, and reports final flags on a one-cycle done pulse.
- Sits between the decode/issue stage and the register file + byte ALU.

Parameters:
- REG_ADDR_W, 4, register index width (16 registers; x0 reads zero).
- PHASE_W, 2, byte-lane select width; NUM_PHASES = 2**PHASE_W = 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  operation request.
- req_ready  output  1  sequencer can accept this cycle.
- req_rs1  input  REG_ADDR_W  source 1 index.
- req_rs2  input  REG_ADDR_W  source 2 index.
- req_rd  input  REG_ADDR_W  destination index.
- req_we  input  1  write result to rd.
- req_cin  input  1  carry into byte 0 (1 for SUB/compare).
- flush  input  1  squash the in-flight operation.
- rf_phase  output  PHASE_W  byte lane to register file.
- rf_rs1  output  REG_ADDR_W  read index 1.
- rf_rs2  output  REG_ADDR_W  read index 2.
- rf_rd  output  REG_ADDR_W  write index; 0 means no architectural write.
- alu_first  output  1  current phase is byte 0.
- alu_last  output  1  current phase is byte 3.
- alu_cin  output  1  carry into current byte.
- alu_cout  input  1  carry out of current byte.
- alu_zero  input  1  current result byte == 0.
- done_valid  output  1  one-cycle completion pulse.
- done_carry  output  1  final carry out of byte 3.
- done_zero  output  1  all 4 result bytes were zero.

Behaviour:
- The register file writes rd_dat into [rf_rd][rf_phase] on every rising clk edge and has no write enable. The sequencer suppresses a write by driving rf_rd = 0; x0 is hardwired to read zero, so a write to it is harmless.
- States:
  - IDLE: no operation in flight.
  - RUN: phase counter ph_q runs 0..3.
- Reset (rst=1 at an edge): state IDLE, ph_q=0, latched indices 0, carry_q=0, zero_q=1, done_valid=0.
- Output values after reset and whenever in IDLE: rf_phase=0, rf_rs1=rf_rs2=rf_rd=0, alu_first=alu_last=0, alu_cin=0, done_carry=0, done_zero=0.
- req_ready = !flush && (state==IDLE || (state==RUN && ph_q==3)). This allows back-to-back issue.
- Accept (req_valid && req_ready at an edge):
  - Latch rs1, rs2, rd, we.
  - carry_q <= req_cin; zero_q <= 1; ph_q <= 0; state <= RUN.
- RUN cycle outputs:
  - rf_phase = ph_q.
  - rf_rs1/rf_rs2 = latched indices.
  - rf_rd = (we_q && !flush) ? rd_q : 0. This is the only combinational path from an input to rf_rd.
  - alu_first = (ph_q==0); alu_last = (ph_q==3); alu_cin = carry_q.
- RUN edge without flush: carry_q <= alu_cout; zero_q <= zero_q & alu_zero; ph_q <= ph_q+1.
- Phase 3 edge without flush:
  - done_valid <= 1 next cycle only.
  - done_carry <= alu_cout; done_zero <= zero_q & alu_zero.
  - Then state <= RUN with ph_q=0 if a new request is accepted, else IDLE.
- Latency and throughput:
  - Accept at edge T; bytes 0..3 occupy cycles T+1..T+4.
  - done_valid is high in cycle T+5.
  - Sustained throughput is 1 operation per 4 cycles, with no bubble.
- Flush (RUN only; ignored in IDLE):
  - rf_rd is forced to 0 in the same cycle.
  - At the edge: state <= IDLE, no done pulse, flags are not updated.
  - Bytes written in earlier phases stay written; the issuer must flush before phase 0 for full squash.
  - No request is accepted in a flush cycle.
- rd==0 or we==0: the sequence runs normally and done flags are valid, but rf_rd stays 0 throughout (used for compare/branch).
- Reset mid-RUN: immediate return to IDLE state values; no done pulse; no further writes after that edge.
- Phase counter wraps 3->0 only via accept; never increments in IDLE.

Decomposition:
- Shared package tinyrv_pkg holds:
  - REG_ADDR_W, PHASE_W, NUM_PHASES;
  - the sequencer state enum (IDLE, RUN);
  - the LAST_PHASE constant.
- No sub-module. The phase counter and flag accumulation are small enough to be inline.

Test Plan:
- Reset, then idle 5 cycles -> rf_rd=0, rf_phase=0, req_ready=1, done_valid=0 every cycle.
- Accept rs1=3, rs2=4, rd=5, we=1, cin=0 at T; ALU model gives alu_cout=1,0,0,1 and alu_zero=1,1,0,1 -> expect:
  - rf_phase 0,1,2,3 and rf_rd=5 in T+1..T+4;
  - alu_cin 0,1,0,0;
  - done_valid at T+5 with done_carry=1, done_zero=0.
- Two requests back-to-back (second held valid) -> second accepted at the phase-3 edge; phases 0..3 repeat with no gap; two done pulses 4 cycles apart.
- Request with rd=7, we=0, cin=1, alu_zero=1 all phases -> rf_rd=0 all 4 cycles; done_zero=1.
- flush asserted in phase 1 with rd=9 -> rf_rd=0 that cycle, IDLE next cycle, no done_valid, req_ready=0 during the flush cycle.
- rst asserted in phase 2 -> next cycle all outputs at reset values; no done pulse afterwards.
